// File: rtl/dog_kernel_pipe.sv
// rtl/dog_kernel_pipe.sv - pipelined 5x5 symmetric-kernel DoG convolver with shadow/active coefficient banks
// Optional: DOG_SAT_EN clamps the result to OUT_W and flags out_sat; otherwise the result wraps.
module dog_kernel_pipe #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 12,
    parameter int OUT_W  = 24,
    parameter int SHIFT  = 0,
    parameter int K0     = 476,
    parameter int K1     = -60,
    parameter int K2     = -30,
    parameter int K3     = -10,
    parameter int K4     = -8,
    parameter int K5     = -2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [25*PIX_W-1:0]   win,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [OUT_W-1:0]      out_dog,
    output logic                  out_sat,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_addr,
    input  logic [COEF_W-1:0]     cfg_data,
    input  logic                  cfg_commit
);
    localparam int ACC_W  = PIX_W + COEF_W + 6;
    localparam int SUM_W  = PIX_W + 3;
    localparam int EXT_W  = (OUT_W > ACC_W + 1) ? OUT_W : ACC_W + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [ACC_W:0] RND = (SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RND_SH) : '0;
`ifdef DOG_SAT_EN
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'({(OUT_W-1){1'b1}});
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef logic signed [COEF_W-1:0] coef_t;

    // Class index from the sorted absolute offsets to the window centre.
    function automatic logic [2:0] class_of(input int r, input int c);
        int dr, dc, lo, hi;
        dr = (r > 2) ? r - 2 : 2 - r;
        dc = (c > 2) ? c - 2 : 2 - c;
        lo = (dr < dc) ? dr : dc;
        hi = (dr < dc) ? dc : dr;
        if (hi == 0) return 3'd0;
        if (hi == 1) return (lo == 0) ? 3'd1 : 3'd2;
        return (lo == 0) ? 3'd3 : ((lo == 1) ? 3'd4 : 3'd5);
    endfunction

    function automatic coef_t k_reset(input int i);
        case (i)
            0:       return COEF_W'(K0);
            1:       return COEF_W'(K1);
            2:       return COEF_W'(K2);
            3:       return COEF_W'(K3);
            4:       return COEF_W'(K4);
            default: return COEF_W'(K5);
        endcase
    endfunction

    coef_t                   shadow_q [6], shadow_d [6];
    coef_t                   active_q [6], active_d [6];
    logic [SUM_W-1:0]        s1_sum_q [6], s1_sum_d [6];
    logic signed [ACC_W-1:0] s2_p_q [6],   s2_p_d [6];
    logic signed [ACC_W-1:0] s3_a_q [3],   s3_a_d [3];
    logic                    s1_v_q, s2_v_q, s3_v_q, out_valid_q;
    logic                    s1_v_d, s2_v_d, s3_v_d, out_valid_d;
    logic [OUT_W-1:0]        out_dog_q, out_dog_d;
    logic                    out_sat_q, out_sat_d;
    logic signed [ACC_W:0]   s4_tot, s4_rnd;
    logic signed [EXT_W-1:0] s4_ext;
    logic                    en;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_dog   = out_dog_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;

    // Commit copies the pre-edge shadow, so a same-cycle write only reaches the shadow.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (cfg_commit) active_d = shadow_q;
        if (cfg_we && cfg_addr < 3'd6) shadow_d[cfg_addr] = cfg_data;
    end

    always_comb begin
        for (int k = 0; k < 6; k++) s1_sum_d[k] = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                s1_sum_d[class_of(r, c)] += SUM_W'(win[(r*5+c)*PIX_W +: PIX_W]);
        for (int k = 0; k < 6; k++)
            s2_p_d[k] = $signed({{(ACC_W-SUM_W){1'b0}}, s1_sum_q[k]}) * ACC_W'(active_q[k]);
        s3_a_d[0] = s2_p_q[0] + s2_p_q[1];
        s3_a_d[1] = s2_p_q[2] + s2_p_q[3];
        s3_a_d[2] = s2_p_q[4] + s2_p_q[5];
        s1_v_d      = in_valid;
        s2_v_d      = s1_v_q;
        s3_v_d      = s2_v_q;
        out_valid_d = s3_v_q;
    end

    always_comb begin
        s4_tot    = (ACC_W+1)'(s3_a_q[0]) + (ACC_W+1)'(s3_a_q[1]) + (ACC_W+1)'(s3_a_q[2]);
        s4_rnd    = (s4_tot + $signed(RND)) >>> SHIFT;
        s4_ext    = EXT_W'(s4_rnd);
        out_dog_d = OUT_W'(s4_ext);
        out_sat_d = 1'b0;
`ifdef DOG_SAT_EN
        if (s4_ext > SAT_MAX) begin
            out_dog_d = SAT_MAX[OUT_W-1:0];
            out_sat_d = s3_v_q;
        end else if (s4_ext < SAT_MIN) begin
            out_dog_d = SAT_MIN[OUT_W-1:0];
            out_sat_d = s3_v_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= k_reset(i);
                active_q[i] <= k_reset(i);
                s1_sum_q[i] <= '0;
                s2_p_q[i]   <= '0;
            end
            for (int j = 0; j < 3; j++) s3_a_q[j] <= '0;
            s1_v_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            s3_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_dog_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            if (en) begin
                s1_sum_q    <= s1_sum_d;
                s2_p_q      <= s2_p_d;
                s3_a_q      <= s3_a_d;
                s1_v_q      <= s1_v_d;
                s2_v_q      <= s2_v_d;
                s3_v_q      <= s3_v_d;
                out_valid_q <= out_valid_d;
                out_dog_q   <= out_dog_d;
                out_sat_q   <= out_sat_d;
            end
        end
    end
endmodule
